// File: rtl/timer_ctrl_pkg.sv
//==============================================================================
// Module      : timer_pkg
// Description : Shared types and constants for the timer peripheral and the
//               control unit that issues TIM_* instructions.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package timer_pkg;

  // Timer sequencing states
  typedef enum logic [1:0] {
    T_STOP = 2'd0,
    T_ARM  = 2'd1,
    T_RUN  = 2'd2
  } timer_state_t;

  // Reset values of the prescaler and auto-reload registers.
  // Both are uniform fills (all zeros / all ones), so any WIDTH can
  // replicate bit 0 to build its own reset value.
  localparam logic [31:0] TIM_PSC_RST = 32'h0000_0000;
  localparam logic [31:0] TIM_ARR_RST = 32'hFFFF_FFFF;

  // funct3 encodings of the TIM_* instructions, decoded by the control unit
  localparam logic [2:0] TIM_ENABLE  = 3'b000;
  localparam logic [2:0] TIM_PSC_I   = 3'b001;
  localparam logic [2:0] TIM_ARR_I   = 3'b010;
  localparam logic [2:0] TIM_PSC_REG = 3'b100;
  localparam logic [2:0] TIM_ARR_REG = 3'b101;
  localparam logic [2:0] TIM_DISABLE = 3'b111;

endpackage

`default_nettype wire

// File: rtl/timer_ctrl_if.sv
//==============================================================================
// Module      : timer_ctrl_if
// Description : Control/status bundle between the control unit/datapath
//               (master) and the timer peripheral (slave).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface timer_ctrl_if #(
  parameter int WIDTH = 32
);

  logic             timer_en;
  logic             timer_read_reg;
  logic [WIDTH-1:0] imm_data;
  logic [WIDTH-1:0] reg_data;
  logic             wr_psc;
  logic             wr_arr;
  logic             ovf_clr;
  logic [WIDTH-1:0] cnt_o;
  logic             ovf_flag;
  logic             irq;
  logic             running;

  modport master (
    output timer_en, timer_read_reg, imm_data, reg_data,
    output wr_psc, wr_arr, ovf_clr,
    input  cnt_o, ovf_flag, irq, running
  );

  modport slave (
    input  timer_en, timer_read_reg, imm_data, reg_data,
    input  wr_psc, wr_arr, ovf_clr,
    output cnt_o, ovf_flag, irq, running
  );

endinterface

`default_nettype wire

// File: rtl/timer_prescaler.sv
//==============================================================================
// Module      : timer_prescaler
// Description : Prescaler counter. Counts 0..psc_act while enabled and emits a
//               combinational tick in the cycle the count equals psc_act.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module timer_prescaler #(
  parameter int WIDTH = 32
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_clear,
  input  wire logic             i_enable,
  input  wire logic [WIDTH-1:0] i_psc_act,
  output logic                  o_tick
);

  logic [WIDTH-1:0] r_psc_cnt;
  logic             w_wrap;

  assign w_wrap = (r_psc_cnt == i_psc_act);
  assign o_tick = i_enable && w_wrap;

  // Prescale counter: cleared on arm, wraps to zero when it reaches psc_act
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_psc_cnt <= '0;
    end else if (i_clear) begin
      r_psc_cnt <= '0;
    end else if (i_enable) begin
      if (w_wrap) r_psc_cnt <= '0;
      else        r_psc_cnt <= r_psc_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/timer_ctrl.sv
//==============================================================================
// Module      : timer_ctrl
// Description : Prescaled up-counting timer with buffered PSC/ARR, sticky
//               overflow flag and one-cycle interrupt pulse per update event.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module timer_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  wire logic   clk,
  input  wire logic   reset,
  timer_ctrl_if.slave bus
);

  localparam logic [WIDTH-1:0] c_psc_rst = {WIDTH{TIM_PSC_RST[0]}};
  localparam logic [WIDTH-1:0] c_arr_rst = {WIDTH{TIM_ARR_RST[0]}};

  timer_state_t     r_state, w_state_nxt;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_psc_pre, r_psc_act;
  logic [WIDTH-1:0] r_arr_pre, r_arr_act;
  logic             r_ovf_flag, r_irq, r_running;

  logic [WIDTH-1:0] w_wdata;
  logic             w_arm, w_stop, w_count_en, w_tick, w_update;

  assign w_wdata  = bus.timer_read_reg ? bus.reg_data : bus.imm_data;
  assign w_update = w_tick && (r_cnt == r_arr_act);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= T_STOP;
    else       r_state <= w_state_nxt;
  end

  // Next-state and state-decoded controls; counting stops on the same edge
  // that disable is sampled, so the frozen value is the one seen before it
  always_comb begin
    w_state_nxt = r_state;
    w_arm       = 1'b0;
    w_stop      = 1'b0;
    w_count_en  = 1'b0;
    case (r_state)
      T_STOP: begin
        w_stop = 1'b1;
        if (bus.timer_en) w_state_nxt = T_ARM;
      end
      T_ARM: begin
        w_arm       = 1'b1;
        w_state_nxt = T_RUN;
      end
      T_RUN: begin
        if (bus.timer_en) w_count_en  = 1'b1;
        else              w_state_nxt = T_STOP;
      end
      default: w_state_nxt = T_STOP;
    endcase
  end

  timer_prescaler #(
    .WIDTH (WIDTH)
  ) u_prescaler (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_arm),
    .i_enable  (w_count_en),
    .i_psc_act (r_psc_act),
    .o_tick    (w_tick)
  );

  // Main counter: cleared on arm and on each update event
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_cnt <= '0;
    else if (w_arm)    r_cnt <= '0;
    else if (w_update) r_cnt <= '0;
    else if (w_tick)   r_cnt <= r_cnt + 1'b1;
  end

  // Preload registers take every write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_psc_pre <= c_psc_rst;
      r_arr_pre <= c_arr_rst;
    end else begin
      if (bus.wr_psc) r_psc_pre <= w_wdata;
      if (bus.wr_arr) r_arr_pre <= w_wdata;
    end
  end

  // Active registers: written directly while stopped, loaded from preload on
  // arm/update; a write coinciding with an update bypasses the preload
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_psc_act <= c_psc_rst;
      r_arr_act <= c_arr_rst;
    end else if (w_stop) begin
      if (bus.wr_psc) r_psc_act <= w_wdata;
      if (bus.wr_arr) r_arr_act <= w_wdata;
    end else if (w_arm) begin
      r_psc_act <= r_psc_pre;
      r_arr_act <= r_arr_pre;
    end else if (w_update) begin
      r_psc_act <= bus.wr_psc ? w_wdata : r_psc_pre;
      r_arr_act <= bus.wr_arr ? w_wdata : r_arr_pre;
    end
  end

  // Status outputs: overflow set has priority over clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf_flag <= 1'b0;
      r_irq      <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_irq     <= w_update;
      r_running <= (w_state_nxt == T_RUN);
      if (w_update)         r_ovf_flag <= 1'b1;
      else if (bus.ovf_clr) r_ovf_flag <= 1'b0;
    end
  end

  assign bus.cnt_o    = r_cnt;
  assign bus.ovf_flag = r_ovf_flag;
  assign bus.irq      = r_irq;
  assign bus.running  = r_running;

endmodule

`default_nettype wire

// File: doc/timer_ctrl.md
# timer_ctrl

Memory-less timer peripheral sequenced by the control unit's TIM_* instructions. It holds prescaler (PSC) and auto-reload (ARR) configuration, runs a prescaled up-counter, and raises an overflow flag and a one-cycle interrupt pulse. PSC/ARR writes are buffered in preload registers and applied atomically at each update event. It sits beside the ALU, driven by the `timer_en` and `timer_read_reg` decode outputs plus write strobes from the datapath.

## Interface
- `WIDTH`, 32: width of PSC, ARR, counter and data ports.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `timer_en` in 1: level enable from control unit (1 = run, 0 = stop).
- `timer_read_reg` in 1: write-data source select (0 = `imm_data`, 1 = `reg_data`).
- `imm_data` in WIDTH: immediate operand.
- `reg_data` in WIDTH: rs1 operand.
- `wr_psc` in 1: write strobe for PSC preload.
- `wr_arr` in 1: write strobe for ARR preload.
- `ovf_clr` in 1: clear overflow flag.
- `cnt_o` out WIDTH: current counter value.
- `ovf_flag` out 1: sticky overflow flag.
- `irq` out 1: one-cycle pulse on each overflow.
- `running` out 1: high in RUN state.

## Operation
- Write data: `wdata = timer_read_reg ? reg_data : imm_data`.
- If `wr_psc` and `wr_arr` are both high in the same cycle, both are written.
- States: STOP, ARM, RUN.
  - STOP: counters hold; `timer_en=1` moves to ARM.
  - ARM: `psc_cnt<=0`, `cnt<=0`, `psc_act<=psc_pre`, `arr_act<=arr_pre`; moves to RUN unconditionally. If `timer_en=0` is sampled in ARM, still go to RUN, then STOP on the next edge.
  - RUN: `timer_en=0` moves to STOP with counters frozen. Re-enable always passes through ARM, so there is no resume.
- Prescaler in RUN: if `psc_cnt==psc_act`, then `psc_cnt<=0` and tick; else `psc_cnt++`.
- Counter on tick: if `cnt==arr_act`, it is an update event: `cnt<=0`, `ovf_flag<=1`, `irq<=1`, `psc_act<=psc_pre`, `arr_act<=arr_pre`. Otherwise `cnt++`.
- Overflow period = (PSC+1)*(ARR+1) cycles. ARR=0 overflows on every tick; PSC=0 ticks every cycle.
- Writes in STOP update both preload and active registers.
- Writes in ARM/RUN update the preload only. Exception: a write in the same cycle as an update event loads `wdata` into both preload and active (write wins).
- `ovf_clr` and an overflow set in the same cycle: set wins.
- All arithmetic is unsigned, WIDTH bits. Equality compare only, so no wrap beyond ARR.

## Timing
- Reset values: state STOP, `cnt_o=0`, `psc_cnt=0`, `ovf_flag=0`, `irq=0`, `running=0`, `psc_pre=psc_act=0`, `arr_pre=arr_act={WIDTH{1}}`.
- All outputs are registered. `irq` is high exactly one cycle per update event.
- `timer_en` is sampled high at edge k: ARM after k, RUN after k+1 (`cnt=0`), first increment at k+2 when PSC=0.
- Reset asserted mid-run returns every register to its reset value immediately, without waiting for a clock edge.

## Structure
- Package `timer_pkg` holds:
  - `timer_state_t` enum {T_STOP, T_ARM, T_RUN}.
  - Constants `TIM_PSC_RST` and `TIM_ARR_RST`.
  - Shared with the control unit: funct3 encodings TIM_ENABLE=000, TIM_PSC_I=001, TIM_ARR_I=010, TIM_PSC_REG=100, TIM_ARR_REG=101, TIM_DISABLE=111.
- One sub-module, `timer_prescaler`: `psc_cnt` register plus tick generation, with inputs clear/enable/`psc_act`.

## Test plan
- Reset, write PSC=0 and ARR=3 in STOP, enable at edge k: `cnt_o` reads 0,1,2,3,0 after edges k+1..k+5; `irq` high only after k+5 and k+9; `ovf_flag=1`.
- PSC=2, ARR=1: `irq` period is 6 cycles; `cnt_o` changes every 3rd cycle in RUN.
- While running with ARR=3, write ARR=7 via `reg_data` with `timer_read_reg=1`: the current period still ends at 3; the next period counts to 7 (32 cycles at PSC=3).
- Write ARR=5 in the exact cycle of an update event: the next period uses 5.
- Assert `ovf_clr` together with an overflow: `ovf_flag` stays 1. Assert `ovf_clr` alone next cycle: `ovf_flag` goes to 0.
- Disable with `cnt=2`: `cnt_o` holds 2 and `running=0`. Re-enable: ARM clears `cnt_o` to 0. Assert `reset` mid-RUN: all outputs go to their reset values asynchronously.
